// File: rtl/axis_skew_feeder.sv
// AXI-Stream ingress register for the systolic skew buffer; appends N-1 pad beats after each tlast.
// Optional macro FEEDER_PAD_HOLD_EN: pad beats repeat the last real vector instead of zero.
module axis_skew_feeder #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] s_axis_tdata,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    input  logic           s_axis_tlast,
    input  logic           m_ready,
    output logic [N*W-1:0] x,
    output logic           cen,
    output logic           x_valid,
    output logic           x_pad,
    output logic           x_last,
    output logic           busy
);
    localparam int unsigned   PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] PADS   = PW'(N - 1);
    localparam logic [PW-1:0] ONE    = PW'(1);
    localparam bit            SINGLE = (N == 1);

    typedef enum logic {STREAM, FLUSH} state_t;

    state_t         r_state,   w_state_nxt;
    logic [PW-1:0]  r_pad_cnt, w_cnt_nxt;
    logic [N*W-1:0] r_x,       w_x_nxt;
    logic           r_x_valid, w_valid_nxt;
    logic           r_x_pad,   w_pad_nxt;
    logic           r_x_last,  w_last_nxt;
    logic           w_load_ok;
    logic [N*W-1:0] w_pad_data;

`ifdef FEEDER_PAD_HOLD_EN
    // x still holds the last real vector while pads are being issued
    assign w_pad_data = r_x;
`else
    assign w_pad_data = '0;
`endif

    assign w_load_ok = !r_x_valid || m_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_pad_cnt;
        w_x_nxt       = r_x;
        w_valid_nxt   = r_x_valid;
        w_pad_nxt     = r_x_pad;
        w_last_nxt    = r_x_last;
        s_axis_tready = 1'b0;
        case (r_state)
            STREAM: begin
                s_axis_tready = w_load_ok;
                if (w_load_ok) begin
                    if (s_axis_tvalid) begin
                        w_x_nxt     = s_axis_tdata;
                        w_valid_nxt = 1'b1;
                        w_pad_nxt   = 1'b0;
                        w_last_nxt  = s_axis_tlast && SINGLE;
                        if (s_axis_tlast && !SINGLE) begin
                            w_state_nxt = FLUSH;
                            w_cnt_nxt   = PADS;
                        end
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_pad_nxt   = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (w_load_ok) begin
                    w_x_nxt     = w_pad_data;
                    w_valid_nxt = 1'b1;
                    w_pad_nxt   = 1'b1;
                    w_cnt_nxt   = r_pad_cnt - ONE;
                    w_last_nxt  = (r_pad_cnt == ONE);
                    if (r_pad_cnt == ONE) begin
                        w_state_nxt = STREAM;
                    end
                end
            end
            default: w_state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= STREAM;
            r_pad_cnt <= '0;
            r_x       <= '0;
            r_x_valid <= 1'b0;
            r_x_pad   <= 1'b0;
            r_x_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pad_cnt <= w_cnt_nxt;
            r_x       <= w_x_nxt;
            r_x_valid <= w_valid_nxt;
            r_x_pad   <= w_pad_nxt;
            r_x_last  <= w_last_nxt;
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign x_pad   = r_x_pad;
    assign x_last  = r_x_last;
    assign cen     = r_x_valid && m_ready;
    assign busy    = (r_state == FLUSH) || r_x_valid;

endmodule

// File: tb/tb_axis_skew_feeder.sv
// Self-checking bench for axis_skew_feeder (N=4, W=8): directed vector table,
// hand-written reset/stream sequences, and randomized traffic against a beat-queue model.
module tb_axis_skew_feeder;
    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned NW = N * W;
`ifdef FEEDER_PAD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] tdata;
    logic          tvalid, tready, tlast, m_ready;
    logic [NW-1:0] x;
    logic          cen, x_valid, x_pad, x_last, busy;

    int total = 0;
    int bad   = 0;

    axis_skew_feeder #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tlast(tlast), .m_ready(m_ready),
        .x(x), .cen(cen), .x_valid(x_valid), .x_pad(x_pad), .x_last(x_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          tv;
        logic [NW-1:0] d;
        logic          tl;
        logic          mr;
        logic          e_rdy;
        logic [NW-1:0] e_x;
        logic          e_v;
        logic          e_p;
        logic          e_l;
    } vec_t;

    function automatic vec_t mk(input logic tv, input logic [NW-1:0] d, input logic tl,
                                input logic mr, input logic e_rdy, input logic [NW-1:0] e_x,
                                input logic e_v, input logic e_p, input logic e_l);
        vec_t v;
        v.tv = tv; v.d = d; v.tl = tl; v.mr = mr;
        v.e_rdy = e_rdy; v.e_x = e_x; v.e_v = e_v; v.e_p = e_p; v.e_l = e_l;
        return v;
    endfunction

    function automatic logic [NW-1:0] padv(input logic [NW-1:0] real_d);
        return HOLD ? real_d : '0;
    endfunction

    typedef struct packed {
        logic [NW-1:0] d;
        logic          pad;
        logic          last;
    } beat_t;

    vec_t          tbl[22];
    beat_t         q[$];
    beat_t         b;
    logic [NW-1:0] va, vaa, vbb, vc, vd;
    logic          e_v, e_rdy;
    int            pend;

    initial begin
        va  = 32'h04030201;
        vaa = 32'h000000AA;
        vbb = 32'h000000BB;
        vc  = 32'h11223344;
        vd  = 32'hDEADBEEF;
        // inputs for one cycle, tready before the edge, then registered outputs after it
        tbl[0]  = mk(1, va,  1, 1, 1, va,         1, 0, 0);
        tbl[1]  = mk(0, '0,  0, 1, 0, padv(va),   1, 1, 0);
        tbl[2]  = mk(0, '0,  0, 1, 0, padv(va),   1, 1, 0);
        tbl[3]  = mk(0, '0,  0, 1, 0, padv(va),   1, 1, 1);
        tbl[4]  = mk(0, '0,  0, 1, 1, '0,         0, 0, 0);
        tbl[5]  = mk(1, vaa, 1, 1, 1, vaa,        1, 0, 0);
        tbl[6]  = mk(1, vbb, 1, 1, 0, padv(vaa),  1, 1, 0);
        tbl[7]  = mk(1, vbb, 1, 1, 0, padv(vaa),  1, 1, 0);
        tbl[8]  = mk(1, vbb, 1, 1, 0, padv(vaa),  1, 1, 1);
        tbl[9]  = mk(1, vbb, 1, 1, 1, vbb,        1, 0, 0);
        tbl[10] = mk(0, '0,  0, 1, 0, padv(vbb),  1, 1, 0);
        tbl[11] = mk(0, '0,  0, 1, 0, padv(vbb),  1, 1, 0);
        tbl[12] = mk(0, '0,  0, 1, 0, padv(vbb),  1, 1, 1);
        tbl[13] = mk(0, '0,  0, 1, 1, '0,         0, 0, 0);
        tbl[14] = mk(1, vc,  1, 1, 1, vc,         1, 0, 0);
        tbl[15] = mk(0, '0,  0, 0, 0, vc,         1, 0, 0);
        tbl[16] = mk(0, '0,  0, 1, 0, padv(vc),   1, 1, 0);
        tbl[17] = mk(0, '0,  0, 0, 0, padv(vc),   1, 1, 0);
        tbl[18] = mk(0, '0,  0, 1, 0, padv(vc),   1, 1, 0);
        tbl[19] = mk(0, '0,  0, 1, 0, padv(vc),   1, 1, 1);
        tbl[20] = mk(0, '0,  0, 0, 0, padv(vc),   1, 1, 1);
        tbl[21] = mk(0, '0,  0, 1, 1, '0,         0, 0, 0);

        rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_x", x, '0);
        chk("rst_valid", x_valid, 0);
        chk("rst_pad", x_pad, 0);
        chk("rst_last", x_last, 0);
        chk("rst_tready", tready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cen", cen, 0);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            tvalid = tbl[i].tv; tdata = tbl[i].d; tlast = tbl[i].tl; m_ready = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d_tready", i), tready, tbl[i].e_rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), x_valid, tbl[i].e_v);
            chk($sformatf("tbl%0d_pad", i), x_pad, tbl[i].e_p);
            chk($sformatf("tbl%0d_last", i), x_last, tbl[i].e_l);
            if (tbl[i].e_v) chk($sformatf("tbl%0d_x", i), x, tbl[i].e_x);
        end

        // reset pulsed while the second pad is loading
        tvalid = 1'b1; tdata = vd; tlast = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        @(negedge clk);
        chk("mid_pad1", x_pad, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_x", x, '0);
        chk("mid_rst_valid", x_valid, 0);
        chk("mid_rst_pad", x_pad, 0);
        chk("mid_rst_last", x_last, 0);
        rst = 1'b0;
        #1;
        chk("mid_rel_tready", tready, 1);
        chk("mid_rel_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_last", x_last, 0);
            chk("mid_no_valid", x_valid, 0);
        end

        // five back-to-back beats with no tlast
        for (int k = 1; k <= 5; k++) begin
            tvalid = 1'b1; tdata = NW'(k) * 32'h01010101; tlast = 1'b0; m_ready = 1'b1;
            #1;
            chk("strm_tready", tready, 1);
            @(negedge clk);
            chk("strm_x", x, NW'(k) * 32'h01010101);
            chk("strm_pad", x_pad, 0);
            chk("strm_cen", cen, 1);
        end
        tvalid = 1'b0;
        @(negedge clk);
        chk("strm_drained", x_valid, 0);

        // randomized traffic against the beat-queue model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            tvalid  = ($urandom_range(0, 9) < 7);
            tdata   = $urandom();
            tlast   = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 9) < 6);
            #1;
            e_v   = (q.size() != 0);
            pend  = e_v ? q.size() - 1 : 0;
            e_rdy = (pend == 0) && (!e_v || m_ready);
            chk("rnd_tready", tready, e_rdy);
            chk("rnd_valid", x_valid, e_v);
            chk("rnd_busy", busy, e_v);
            chk("rnd_cen", cen, e_v && m_ready);
            if (e_v) begin
                chk("rnd_x", x, q[0].d);
                chk("rnd_pad", x_pad, q[0].pad);
                chk("rnd_last", x_last, q[0].last);
            end
            if (e_v && m_ready) void'(q.pop_front());
            if (tvalid && e_rdy) begin
                b.d = tdata; b.pad = 1'b0; b.last = tlast && (N == 1);
                q.push_back(b);
                if (tlast) begin
                    for (int p = 1; p < N; p++) begin
                        b.d = padv(tdata); b.pad = 1'b1; b.last = (p == N - 1);
                        q.push_back(b);
                    end
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
